// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode: in-order buffer of {pc, instr} pairs
// with a head predecode illegal flag and a single-cycle flush for redirects.
module if_id_queue #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_valid,
    output logic          if_ready,
    input  logic [31:0]   if_pc,
    input  logic [31:0]   if_instr,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [31:0]   id_pc,
    output logic [31:0]   id_instr,
    output logic          id_illegal,
    input  logic          flush,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [31:0]   mem_pc_q    [DEPTH];
    logic [31:0]   mem_instr_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    logic          enq;
    logic          deq;
    logic [31:0]   head_pc;
    logic [31:0]   head_instr;

    // if_ready looks only at occupancy, so a full queue refuses even while draining.
    always_comb begin
        if_ready = (count_q != FULL_CNT);
        id_valid = (count_q != '0) && !flush;
        enq      = if_valid && if_ready && !flush;
        deq      = id_valid && id_ready;
        count    = count_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
            if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
            if (enq && !deq)      count_d = count_q + 1'b1;
            else if (deq && !enq) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_pc_q[wr_ptr_q]    <= if_pc;
            mem_instr_q[wr_ptr_q] <= if_instr;
        end
    end

    always_comb begin
        head_pc    = mem_pc_q[rd_ptr_q];
        head_instr = mem_instr_q[rd_ptr_q];
        id_pc      = id_valid ? head_pc    : 32'h0;
        id_instr   = id_valid ? head_instr : 32'h0;
        id_illegal = id_valid && ((head_instr[1:0] != 2'b11) || (head_instr == 32'h0));
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=4).
module tb_if_id_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_illegal;
    logic        flush;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    if_id_queue #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_pc      (id_pc),
        .id_instr   (id_instr),
        .id_illegal (id_illegal),
        .flush      (flush),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        if_valid = 1'b1;
        if_pc    = pc;
        if_instr = instr;
        tick();
        if_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_valid = 1'b0; if_pc = '0; if_instr = '0;
        id_ready = 1'b0; flush = 1'b0;
        #2;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %b want 0", id_valid); end
        n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL reset_if_ready: got %b want 1", if_ready); end
        n_checks++; if ({id_pc, id_instr, id_illegal} !== 65'h0) begin n_fail++; $display("FAIL reset_id_outputs: got pc=%h instr=%h ill=%b want 0", id_pc, id_instr, id_illegal); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill_drain();
        id_ready = 1'b0;
        for (int k = 0; k < 4; k++) push(32'(4*k), 32'h13 + 32'(k));
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", count); end
        n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL fill_if_ready: got %b want 0", if_ready); end
        n_checks++; if (id_pc !== 32'h0 || id_instr !== 32'h13) begin n_fail++; $display("FAIL fill_head: got pc=%h instr=%h want pc=0 instr=13", id_pc, id_instr); end
        push(32'h10, 32'h99);
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_refuse_5th: got count %0d want 4", count); end
        // full while draining: dequeue fires, enqueue still refused
        if_valid = 1'b1; if_pc = 32'h10; if_instr = 32'h99; id_ready = 1'b1;
        #1;
        n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_id_ready_path: got %b want 0", if_ready); end
        tick();
        if_valid = 1'b0;
        n_checks++; if (count !== 3'd3 || if_ready !== 1'b1) begin n_fail++; $display("FAIL full_deq: got count=%0d if_ready=%b want 3/1", count, if_ready); end
        for (int k = 1; k < 4; k++) begin
            n_checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'(4*k) || id_instr !== 32'h13 + 32'(k)) begin
                n_fail++; $display("FAIL drain_%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", k, id_valid, id_pc, id_instr, 32'(4*k), 32'h13 + 32'(k));
            end
            tick();
        end
        n_checks++; if (count !== 3'd0 || id_valid !== 1'b0 || id_pc !== 32'h0) begin n_fail++; $display("FAIL drain_empty: got count=%0d v=%b pc=%h want 0/0/0", count, id_valid, id_pc); end
        id_ready = 1'b0;
    endtask

    task automatic test_streaming();
        if_valid = 1'b1; id_ready = 1'b1;
        if_pc = 32'h100; if_instr = 32'h1000_0013;
        tick();
        for (int i = 1; i < 20; i++) begin
            if_pc = 32'h100 + 32'(4*i); if_instr = 32'h1000_0013 + 32'(i);
            #1;
            n_checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'h100 + 32'(4*(i-1)) || count !== 3'd1) begin
                n_fail++; $display("FAIL stream_%0d: got v=%b pc=%h count=%0d want v=1 pc=%h count=1", i, id_valid, id_pc, count, 32'h100 + 32'(4*(i-1)));
            end
            tick();
        end
        if_valid = 1'b0;
        n_checks++; if (id_pc !== 32'h14C || count !== 3'd1) begin n_fail++; $display("FAIL stream_last: got pc=%h count=%0d want 14c/1", id_pc, count); end
        tick();
        n_checks++; if (count !== 3'd0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL stream_empty: got count=%0d v=%b want 0/0", count, id_valid); end
        id_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_instr;
        id_ready = 1'b0;
        for (int k = 0; k < 3; k++) push(32'h400 + 32'(4*k), 32'hA000_0003 + 32'(k << 4));
        id_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_instr = 32'hA000_0003 + 32'(k << 4);
            n_checks++;
            if (id_pc !== 32'h400 + 32'(4*k) || id_instr !== exp_instr) begin
                n_fail++; $display("FAIL wrap_a_%0d: got pc=%h instr=%h want pc=%h instr=%h", k, id_pc, id_instr, 32'h400 + 32'(4*k), exp_instr);
            end
            tick();
        end
        id_ready = 1'b0;
        for (int k = 0; k < 4; k++) push(32'h500 + 32'(4*k), 32'hB000_0007 + 32'(k << 8));
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL wrap_full: got count %0d want 4", count); end
        id_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_instr = 32'hB000_0007 + 32'(k << 8);
            n_checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'h500 + 32'(4*k) || id_instr !== exp_instr) begin
                n_fail++; $display("FAIL wrap_b_%0d: got v=%b pc=%h instr=%h want pc=%h instr=%h", k, id_valid, id_pc, id_instr, 32'h500 + 32'(4*k), exp_instr);
            end
            tick();
        end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL wrap_empty: got count %0d want 0", count); end
        id_ready = 1'b0;
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) push(32'h600 + 32'(4*k), 32'h0000_0013);
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 3", count); end
        flush = 1'b1; if_valid = 1'b1; if_pc = 32'h200; if_instr = 32'h0000_0013; id_ready = 1'b1;
        #1;
        n_checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== 32'h0) begin n_fail++; $display("FAIL flush_same_cycle: got v=%b pc=%h instr=%h want 0/0/0", id_valid, id_pc, id_instr); end
        tick();
        flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
        n_checks++; if (count !== 3'd0 || id_valid !== 1'b0 || if_ready !== 1'b1) begin n_fail++; $display("FAIL flush_after: got count=%0d v=%b rdy=%b want 0/0/1", count, id_valid, if_ready); end
        flush = 1'b1;
        tick();
        tick();
        flush = 1'b0;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_repeat: got count %0d want 0", count); end
        push(32'h300, 32'h0050_0093);
        n_checks++; if (count !== 3'd1 || id_valid !== 1'b1 || id_pc !== 32'h300) begin n_fail++; $display("FAIL flush_next_head: got count=%0d v=%b pc=%h want 1/1/300", count, id_valid, id_pc); end
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
    endtask

    task automatic test_predecode();
        logic [31:0] instrs [3];
        logic        exp_ill [3];
        instrs[0] = 32'h0000_0000; exp_ill[0] = 1'b1;
        instrs[1] = 32'h0000_0002; exp_ill[1] = 1'b1;
        instrs[2] = 32'h0050_0093; exp_ill[2] = 1'b0;
        for (int k = 0; k < 3; k++) push(32'h700 + 32'(4*k), instrs[k]);
        id_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (id_valid !== 1'b1 || id_instr !== instrs[k] || id_illegal !== exp_ill[k]) begin
                n_fail++; $display("FAIL predecode_%0d: got v=%b instr=%h ill=%b want instr=%h ill=%b", k, id_valid, id_instr, id_illegal, instrs[k], exp_ill[k]);
            end
            tick();
        end
        n_checks++; if (id_illegal !== 1'b0) begin n_fail++; $display("FAIL predecode_empty: got ill=%b want 0", id_illegal); end
        id_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        push(32'h800, 32'h0000_0013);
        push(32'h804, 32'h0000_0013);
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL areset_pre: got count %0d want 2", count); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (id_valid !== 1'b0 || count !== 3'd0 || if_ready !== 1'b1 || id_pc !== 32'h0) begin
            n_fail++; $display("FAIL areset_immediate: got v=%b count=%0d rdy=%b pc=%h want 0/0/1/0", id_valid, count, if_ready, id_pc);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (count !== 3'd0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL areset_after: got count=%0d v=%b want 0/0", count, id_valid); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_streaming();
        test_wrap();
        test_flush();
        test_predecode();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
